alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle control unit that sequences the 16-bit ALU: accepts 8-bit instruction words over a valid/ready handshake.
//  Decodes each word into ALU Operation, bus source selects and register write strobes.
//  Tracks the ALU Z flag for conditional jumps. Sits between instruction fetch and datapath (register file + ALU).
// PARAMETERS
//  REG_SEL_W   2    width of register index (4 registers R0..R3)
//  CNT_W       16   width of performance counters (optional feature only)
// PORTS
//  Clock        in   1   single clock; all state updates on rising edge
//  ResetN       in   1   synchronous, active-low reset
//  InstrValid   in   1   instruction word valid
//  InstrReady   out  1   sequencer can accept a word (IDLE only)
//  Instr        in   8   [7:4] opcode, [3:2] RA (dest/BusA src), [1:0] RB (BusB src)
//  FlagZ        in   1   Z flag from ALU, sampled during EXEC
//  Operation    out  3   ALU operation code
//  SelA         out  2   register driven onto BusA
//  SelB         out  2   register driven onto BusB
//  WriteEn      out  1   write BusC into register SelA this cycle
//  JumpTaken    out  1   1-cycle pulse: JZ executed with Z=1
//  IllegalOp    out  1   1-cycle pulse: reserved opcode executed
//  Halted       out  1   HALT executed; sticky until reset
// BEHAVIOUR
//  - All outputs registered. Reset values: InstrReady=1 on 1st cycle after reset; all others 0 (Operation=000).
//  - FSM: IDLE -> DECODE -> EXEC -> IDLE; HALT state is terminal.
//    IDLE: InstrReady=1; transfer when InstrValid&&InstrReady; word latched; -> DECODE.
//    DECODE: InstrReady=0; Operation/SelA/SelB loaded from latched word; -> EXEC.
//    EXEC: ALU settles combinationally; WriteEn=1 for writing ops. ZReg<=FlagZ on SUB/MOV only.
//      JZ: JumpTaken=1 iff ZReg==1. -> IDLE (or HALT for HALT opcode).
//  - Latency: word accepted at edge N; WriteEn/JumpTaken high in cycle N+2; InstrReady high again N+3.
//    Throughput 1 instr / 3 cycles.
//  - Opcode map (Operation, WriteEn):
//    0 NOP(000,0); 1 ADD(100,1); 2 SUB(101,1); 3 MUL4(110,1); 4 DIV2(111,1); 5 MOV(001,1); 6 CLR(000,1);
//    7 JZ(000,0); 8 HALT(000,0); 9-15 reserved -> NOP behaviour + IllegalOp pulse in EXEC.
//  - ZReg (internal) reset 0; unaffected by ADD/MUL4/DIV2/CLR/NOP/JZ. Back-to-back SUB then JZ sees new Z.
//  - Operation/SelA/SelB held stable from DECODE through EXEC; return to 0 in IDLE.
//  - InstrValid while not IDLE is ignored (no transfer). Instr only sampled on transfer.
//  - HALT: Halted=1 from cycle after EXEC; InstrReady stays 0 until ResetN=0.
//  - ResetN=0 in any state (incl. EXEC, HALT) -> next edge: IDLE, ZReg=0, all outputs reset values.
//    An in-flight instruction is dropped with no WriteEn at/after the reset edge.
// CONFIGURATION
//  ALU_SEQ_PERF_EN defined: adds outputs InstrCount[CNT_W] (+1 per EXEC) and StallCount[CNT_W]
//    (+1 per IDLE cycle with InstrValid=0). Both counters wrap at 2^CNT_W-1 -> 0 and clear on reset.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package alu_seq_pkg: ALU operation constants (ADD=100, SUB=101, MUL4=110, DIV2=111, CLR=000, PASS=001),
//    opcode enum, FSM state enum.
//  Sub-module alu_instr_decode: combinational opcode -> {Operation, WriteEn, isJZ, isHalt, illegal}.
//  Top holds FSM, instruction latch, ZReg, output registers, optional counters.
// TESTING
//  1 Reset: ResetN=0 2 cycles -> InstrReady=1, Operation=000, WriteEn=0, Halted=0.
//  2 Instr=8'h16 (ADD R1,R2) valid at edge N -> cycle N+2: Operation=100, SelA=1, SelB=2, WriteEn=1; InstrReady=1 at N+3.
//  3 SUB with FlagZ=1 in EXEC, then JZ (8'h70) -> JumpTaken=1 one cycle.
//    Repeat with FlagZ=0 -> JumpTaken=0.
//  4 ADD with FlagZ=1 between SUB(Z=0) and JZ -> ZReg unchanged, JumpTaken=0.
//  5 Instr=8'hF0 -> IllegalOp pulse, WriteEn=0. Instr=8'h80 -> Halted=1, InstrReady=0 forever.
//    Then ResetN=0 -> IDLE restored.
//  6 ResetN=0 in EXEC of ADD -> no WriteEn after edge. With ALU_SEQ_PERF_EN, 3 instrs -> InstrCount=3.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: ALU operation codes, opcode enum and FSM state encodings.
package alu_seq_pkg;

  localparam int REG_SEL_W = 2;
  localparam int CNT_W     = 16;

  localparam logic [2:0] ALU_CLR  = 3'b000;
  localparam logic [2:0] ALU_PASS = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_MUL4 = 3'b110;
  localparam logic [2:0] ALU_DIV2 = 3'b111;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL4 = 4'd3,
    OP_DIV2 = 4'd4,
    OP_MOV  = 4'd5,
    OP_CLR  = 4'd6,
    OP_JZ   = 4'd7,
    OP_HALT = 4'd8
  } opcode_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational opcode decoder: maps a 4-bit opcode to the ALU operation, write strobe and control flags.
module alu_instr_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [2:0] operation_o,
  output logic       write_en_o,
  output logic       is_jz_o,
  output logic       is_halt_o,
  output logic       updates_z_o,
  output logic       illegal_o
);

  always_comb begin
    operation_o = ALU_CLR;
    write_en_o  = 1'b0;
    is_jz_o     = 1'b0;
    is_halt_o   = 1'b0;
    updates_z_o = 1'b0;
    illegal_o   = 1'b0;
    case (opcode_i)
      OP_NOP:  ;
      OP_ADD:  begin operation_o = ALU_ADD;  write_en_o = 1'b1; end
      OP_SUB:  begin operation_o = ALU_SUB;  write_en_o = 1'b1; updates_z_o = 1'b1; end
      OP_MUL4: begin operation_o = ALU_MUL4; write_en_o = 1'b1; end
      OP_DIV2: begin operation_o = ALU_DIV2; write_en_o = 1'b1; end
      OP_MOV:  begin operation_o = ALU_PASS; write_en_o = 1'b1; updates_z_o = 1'b1; end
      OP_CLR:  begin operation_o = ALU_CLR;  write_en_o = 1'b1; end
      OP_JZ:   is_jz_o   = 1'b1;
      OP_HALT: is_halt_o = 1'b1;
      // Reserved opcodes execute as NOP but flag the event.
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Three-cycle ALU control sequencer (IDLE -> DECODE -> EXEC) with Z tracking and sticky HALT.
// Optional performance counters are built when ALU_SEQ_PERF_EN is defined.
//
// state  | meaning
// IDLE   | InstrReady high, waiting for a word
// DECODE | latched word is decoded, datapath controls registered
// EXEC   | ALU result written, Z sampled on SUB/MOV
// HALT   | terminal until ResetN low
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int REG_SEL_W = alu_seq_pkg::REG_SEL_W,
  parameter int CNT_W     = alu_seq_pkg::CNT_W
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 InstrValid,
  output logic                 InstrReady,
  input  logic [7:0]           Instr,
  input  logic                 FlagZ,
  output logic [2:0]           Operation,
  output logic [REG_SEL_W-1:0] SelA,
  output logic [REG_SEL_W-1:0] SelB,
  output logic                 WriteEn,
  output logic                 JumpTaken,
  output logic                 IllegalOp,
  output logic                 Halted
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]     InstrCount,
  output logic [CNT_W-1:0]     StallCount
`endif
);

  logic [1:0]           state_q, state_d;
  logic [7:0]           instr_q, instr_d;
  logic                 zreg_q, zreg_d;
  logic [2:0]           op_q, op_d;
  logic [REG_SEL_W-1:0] sela_q, sela_d, selb_q, selb_d;
  logic                 we_q, we_d, jmp_q, jmp_d, ill_q, ill_d;
  logic                 halted_q, halted_d, ready_q, ready_d;

  logic [2:0] dec_op;
  logic       dec_we, dec_jz, dec_halt, dec_upd_z, dec_ill;

  alu_instr_decode u_decode (
    .opcode_i    (instr_q[7:4]),
    .operation_o (dec_op),
    .write_en_o  (dec_we),
    .is_jz_o     (dec_jz),
    .is_halt_o   (dec_halt),
    .updates_z_o (dec_upd_z),
    .illegal_o   (dec_ill)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    zreg_d   = zreg_q;
    op_d     = op_q;
    sela_d   = sela_q;
    selb_d   = selb_q;
    we_d     = 1'b0;
    jmp_d    = 1'b0;
    ill_d    = 1'b0;
    halted_d = halted_q;
    ready_d  = ready_q;
    case (state_q)
      ST_IDLE: begin
        if (InstrValid && ready_q) begin
          instr_d = Instr;
          ready_d = 1'b0;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op_d    = dec_op;
        sela_d  = instr_q[2*REG_SEL_W-1 -: REG_SEL_W];
        selb_d  = instr_q[REG_SEL_W-1:0];
        we_d    = dec_we;
        jmp_d   = dec_jz & zreg_q;
        ill_d   = dec_ill;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_upd_z) zreg_d = FlagZ;
        op_d   = '0;
        sela_d = '0;
        selb_d = '0;
        if (dec_halt) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HALT: ;
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      zreg_q   <= 1'b0;
      op_q     <= '0;
      sela_q   <= '0;
      selb_q   <= '0;
      we_q     <= 1'b0;
      jmp_q    <= 1'b0;
      ill_q    <= 1'b0;
      halted_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      zreg_q   <= zreg_d;
      op_q     <= op_d;
      sela_q   <= sela_d;
      selb_q   <= selb_d;
      we_q     <= we_d;
      jmp_q    <= jmp_d;
      ill_q    <= ill_d;
      halted_q <= halted_d;
      ready_q  <= ready_d;
    end
  end

  assign InstrReady = ready_q;
  assign Operation  = op_q;
  assign SelA       = sela_q;
  assign SelB       = selb_q;
  assign WriteEn    = we_q;
  assign JumpTaken  = jmp_q;
  assign IllegalOp  = ill_q;
  assign Halted     = halted_q;

`ifdef ALU_SEQ_PERF_EN
  logic [CNT_W-1:0] icnt_q, scnt_q;

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      icnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (state_q == ST_EXEC) icnt_q <= icnt_q + 1'b1;
      if (state_q == ST_IDLE && !InstrValid) scnt_q <= scnt_q + 1'b1;
    end
  end

  assign InstrCount = icnt_q;
  assign StallCount = scnt_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: expected EXEC-cycle outputs are queued at issue and compared when the DUT executes.
module tb_alu_sequencer;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic       InstrValid;
  logic       InstrReady;
  logic [7:0] Instr;
  logic       FlagZ;
  logic [2:0] Operation;
  logic [1:0] SelA, SelB;
  logic       WriteEn, JumpTaken, IllegalOp, Halted;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] InstrCount, StallCount;
`endif

  alu_sequencer dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Instr      (Instr),
    .FlagZ      (FlagZ),
    .Operation  (Operation),
    .SelA       (SelA),
    .SelB       (SelB),
    .WriteEn    (WriteEn),
    .JumpTaken  (JumpTaken),
    .IllegalOp  (IllegalOp),
    .Halted     (Halted)
`ifdef ALU_SEQ_PERF_EN
    ,
    .InstrCount (InstrCount),
    .StallCount (StallCount)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       we;
    logic       jmp;
    logic       ill;
    logic       halt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic zm    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] w, input logic z);
    exp_t e;
    e = '0;
    e.sa = w[3:2];
    e.sb = w[1:0];
    case (w[7:4])
      4'd0: ;
      4'd1: begin e.op = 3'b100; e.we = 1'b1; end
      4'd2: begin e.op = 3'b101; e.we = 1'b1; end
      4'd3: begin e.op = 3'b110; e.we = 1'b1; end
      4'd4: begin e.op = 3'b111; e.we = 1'b1; end
      4'd5: begin e.op = 3'b001; e.we = 1'b1; end
      4'd6: begin e.op = 3'b000; e.we = 1'b1; end
      4'd7: e.jmp = z;
      4'd8: e.halt = 1'b1;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic do_reset();
    ResetN     = 1'b0;
    InstrValid = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    ResetN = 1'b1;
    zm     = 1'b0;
    exp_q.delete();
  endtask

  // Issue one word; fz is the Z flag presented by the ALU during its EXEC cycle.
  task automatic send(input logic [7:0] w, input logic fz);
    exp_t g;
    int   t;
    exp_q.push_back(model(w, zm));
    t = 0;
    while (!InstrReady && t < 20) begin
      @(posedge Clock); #1;
      t++;
    end
    chk("ready_wait", InstrReady, 1);
    Instr      = w;
    InstrValid = 1'b1;
    @(posedge Clock); #1;
    chk("ready_decode", InstrReady, 0);
    Instr = ~w;
    @(posedge Clock); #1;
    InstrValid = 1'b0;
    FlagZ      = fz;
    g = exp_q.pop_front();
    chk("exec_op",   Operation, g.op);
    chk("exec_sela", SelA, g.sa);
    chk("exec_selb", SelB, g.sb);
    chk("exec_we",   WriteEn, g.we);
    chk("exec_jmp",  JumpTaken, g.jmp);
    chk("exec_ill",  IllegalOp, g.ill);
    if (w[7:4] == 4'd2 || w[7:4] == 4'd5) zm = fz;
    @(posedge Clock); #1;
    FlagZ = 1'b0;
    chk("post_we",     WriteEn, 0);
    chk("post_jmp",    JumpTaken, 0);
    chk("post_op",     Operation, 0);
    chk("post_ready",  InstrReady, !g.halt);
    chk("post_halted", Halted, g.halt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] opc;
    ResetN     = 1'b0;
    InstrValid = 1'b0;
    Instr      = 8'h00;
    FlagZ      = 1'b0;

    do_reset();
    chk("rst_ready",  InstrReady, 1);
    chk("rst_op",     Operation, 0);
    chk("rst_we",     WriteEn, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_jmp",    JumpTaken, 0);
    chk("rst_ill",    IllegalOp, 0);

    send(8'h16, 1'b0);                  // ADD R1,R2
    send(8'h21, 1'b1);                  // SUB with Z=1
    send(8'h70, 1'b0);                  // JZ taken
    send(8'h2E, 1'b0);                  // SUB with Z=0
    send(8'h70, 1'b0);                  // JZ not taken
    send(8'h23, 1'b0);                  // SUB Z=0
    send(8'h19, 1'b1);                  // ADD must not touch Z
    send(8'h70, 1'b0);
    send(8'h5B, 1'b1);                  // MOV sets Z
    send(8'h70, 1'b0);
    send(8'h64, 1'b0);                  // CLR leaves Z set
    send(8'h70, 1'b0);

    for (int i = 0; i < 16; i++) begin
      opc = i[3:0];
      if (opc != 4'd8) send({opc, 4'($urandom)}, 1'($urandom));
    end

    send(8'hF0, 1'b0);                  // reserved opcode
    send(8'h21, 1'b1);
    send(8'h80, 1'b0);                  // HALT
    InstrValid = 1'b1;
    Instr      = 8'h16;
    repeat (5) @(posedge Clock);
    #1;
    chk("halt_sticky", Halted, 1);
    chk("halt_ready",  InstrReady, 0);
    chk("halt_we",     WriteEn, 0);
    InstrValid = 1'b0;
    do_reset();
    chk("unhalt_ready",  InstrReady, 1);
    chk("unhalt_halted", Halted, 0);
    send(8'h70, 1'b0);                  // Z cleared by reset

    // Reset while ADD is in EXEC.
    Instr      = 8'h16;
    InstrValid = 1'b1;
    @(posedge Clock); #1;
    InstrValid = 1'b0;
    @(posedge Clock); #1;
    chk("mid_exec_we", WriteEn, 1);
    ResetN = 1'b0;
    @(posedge Clock); #1;
    chk("mid_rst_we",    WriteEn, 0);
    chk("mid_rst_ready", InstrReady, 1);
    chk("mid_rst_op",    Operation, 0);
    ResetN = 1'b1;
    zm     = 1'b0;
    @(posedge Clock); #1;
    chk("mid_rst_we2", WriteEn, 0);

`ifdef ALU_SEQ_PERF_EN
    do_reset();
    chk("perf_rst", InstrCount, 0);
    send(8'h16, 1'b0);
    send(8'h25, 1'b0);
    send(8'h00, 1'b0);
    chk("perf_icnt", InstrCount, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
